// File: rtl/axi_fft_frame_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_fft_frame_slave_if
//  Purpose  : AXI4 write/read channel bundle for the FFT frame slave.
//  Revision : 1.0  initial release
// ============================================================================
interface axi_fft_frame_slave_if #(
    parameter int WIDTH_SID = 15,
    parameter int WIDTH_AD  = 14,
    parameter int WIDTH_DA  = 32,
    parameter int WIDTH_DS  = 4
);
    logic [WIDTH_SID-1:0] awid;
    logic [WIDTH_AD-1:0]  awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 awvalid;
    logic                 awready;

    logic [WIDTH_DA-1:0]  wdata;
    logic [WIDTH_DS-1:0]  wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;

    logic [WIDTH_SID-1:0] bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    logic [WIDTH_SID-1:0] arid;
    logic [WIDTH_AD-1:0]  araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arvalid;
    logic                 arready;

    logic [WIDTH_SID-1:0] rid;
    logic [WIDTH_DA-1:0]  rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_fft_frame_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_fft_frame_slave
//  Purpose  : AXI4 slave that streams one frame into an FFT core, buffers the
//             core results and serves them back over read bursts.
//  Revision : 1.0  initial release
// ============================================================================
module axi_fft_frame_slave #(
    parameter int WIDTH_SID = 15,
    parameter int WIDTH_AD  = 14,
    parameter int WIDTH_DA  = 32,
    parameter int WIDTH_DS  = 4,
    parameter int N_PT      = 128,
    parameter int IN_BW     = 16,
    parameter int OUT_BW    = 23
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    axi_fft_frame_slave_if.slave   s_axi,
    output logic                   fft_rst_n,
    output logic                   fft_start,
    output logic                   fft_valid,
    output logic [IN_BW-1:0]       fft_in_re,
    output logic [IN_BW-1:0]       fft_in_im,
    input  logic                   fft_out_valid,
    input  logic [OUT_BW-1:0]      fft_out_re,
    input  logic [OUT_BW-1:0]      fft_out_im
);
    localparam int c_idx_w = $clog2(N_PT);
    localparam int c_cnt_w = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_n_pt = c_cnt_w'(N_PT);

    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;

    localparam logic [1:0] c_w_idle = 2'd0;
    localparam logic [1:0] c_w_addr = 2'd1;
    localparam logic [1:0] c_w_data = 2'd2;
    localparam logic [1:0] c_w_resp = 2'd3;

    localparam logic [1:0] c_r_idle  = 2'd0;
    localparam logic [1:0] c_r_addr  = 2'd1;
    localparam logic [1:0] c_r_fetch = 2'd2;
    localparam logic [1:0] c_r_data  = 2'd3;

    // Encoding doubles as the STATUS frame-state field.
    localparam logic [1:0] c_f_idle    = 2'd0;
    localparam logic [1:0] c_f_load    = 2'd1;
    localparam logic [1:0] c_f_compute = 2'd2;
    localparam logic [1:0] c_f_ready   = 2'd3;

    logic [1:0]           r_w_state, w_w_next;
    logic [1:0]           r_r_state, w_r_next;
    logic [1:0]           r_f_state, w_f_next;

    logic [WIDTH_SID-1:0] r_bid;
    logic [1:0]           r_bresp;
    logic                 r_aw_ctl;
    logic                 r_aw_is_ctrl;

    logic [WIDTH_SID-1:0] r_rid;
    logic [7:0]           r_arlen;
    logic [7:0]           r_rbeat;
    logic                 r_ar_ctl;
    logic                 r_ar_is_status;
    logic [31:0]          r_rdata;
    logic [1:0]           r_rresp;
    logic                 r_rlast;

    logic [c_cnt_w-1:0]   r_in_cnt;
    logic [c_cnt_w-1:0]   r_out_cnt;
    logic [c_cnt_w-1:0]   r_rd_cnt;
    logic                 r_ovf;

    logic                 r_fft_rst_n;
    logic                 r_fft_start;
    logic                 r_fft_valid;
    logic [IN_BW-1:0]     r_fft_in_re;
    logic [IN_BW-1:0]     r_fft_in_im;

    logic [31:0]          r_obuf [N_PT];

    logic                 w_wbeat;
    logic                 w_abort;
    logic                 w_data_beat;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_res;
    logic                 w_rd_ok;
    logic                 w_frame_done;
    logic [12:0]          w_rem;
    logic [31:0]          w_status;
    logic                 w_unused;

    // ------------------------------------------------------------------
    // Beat classification
    // ------------------------------------------------------------------
    assign w_wbeat      = (r_w_state == c_w_data) && s_axi.wvalid;
    assign w_abort      = w_wbeat && r_aw_ctl && r_aw_is_ctrl && s_axi.wdata[0];
    assign w_data_beat  = w_wbeat && !r_aw_ctl;
    assign w_accept     = w_data_beat && !w_abort && (r_in_cnt < c_n_pt) &&
                          ((r_f_state == c_f_idle) || (r_f_state == c_f_load));
    assign w_drop       = w_data_beat && !w_accept;
    // Results may overlap the tail of loading, so capture in LOAD too.
    assign w_res        = fft_out_valid && !w_abort && (r_out_cnt < c_n_pt) &&
                          ((r_f_state == c_f_load) || (r_f_state == c_f_compute));
    assign w_rd_ok      = (r_r_state == c_r_fetch) && !r_ar_ctl && !w_abort &&
                          (r_f_state == c_f_ready) && (r_rd_cnt < c_n_pt);
    assign w_frame_done = (r_f_state == c_f_ready) && (r_rd_cnt == c_n_pt);

    assign w_rem    = (r_f_state == c_f_ready) ? 13'(c_n_pt - r_rd_cnt) : 13'd0;
    assign w_status = {3'b000, w_rem, 13'd0, r_ovf, r_f_state};

    assign w_unused = ^{s_axi.awaddr, s_axi.araddr, s_axi.awsize, s_axi.awburst,
                        s_axi.arsize, s_axi.arburst, s_axi.wstrb};

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_w_state <= c_w_idle;
            r_r_state <= c_r_idle;
            r_f_state <= c_f_idle;
        end else begin
            r_w_state <= w_w_next;
            r_r_state <= w_r_next;
            r_f_state <= w_f_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_w_next = r_w_state;
        case (r_w_state)
            c_w_idle: if (s_axi.awvalid) w_w_next = c_w_addr;
            c_w_addr: w_w_next = c_w_data;
            c_w_data: if (s_axi.wvalid && s_axi.wlast) w_w_next = c_w_resp;
            c_w_resp: if (s_axi.bready) w_w_next = c_w_idle;
            default:  w_w_next = c_w_idle;
        endcase
    end

    always_comb begin
        w_r_next = r_r_state;
        case (r_r_state)
            c_r_idle:  if (s_axi.arvalid) w_r_next = c_r_addr;
            c_r_addr:  w_r_next = c_r_fetch;
            c_r_fetch: w_r_next = c_r_data;
            c_r_data:  if (s_axi.rready) w_r_next = r_rlast ? c_r_idle : c_r_fetch;
            default:   w_r_next = c_r_idle;
        endcase
    end

    always_comb begin
        w_f_next = r_f_state;
        if (w_abort) begin
            w_f_next = c_f_idle;
        end else begin
            case (r_f_state)
                c_f_idle:    if (w_accept) w_f_next = c_f_load;
                c_f_load:    if (r_in_cnt == c_n_pt) w_f_next = c_f_compute;
                c_f_compute: if (r_out_cnt == c_n_pt) w_f_next = c_f_ready;
                c_f_ready:   if (w_frame_done) w_f_next = c_f_idle;
                default:     w_f_next = c_f_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        s_axi.awready = (r_w_state == c_w_addr);
        s_axi.wready  = (r_w_state == c_w_data);
        s_axi.bvalid  = (r_w_state == c_w_resp);
        s_axi.arready = (r_r_state == c_r_addr);
        s_axi.rvalid  = (r_r_state == c_r_data);
    end

    assign s_axi.bid   = r_bid;
    assign s_axi.bresp = r_bresp;
    assign s_axi.rid   = r_rid;
    assign s_axi.rdata = r_rdata;
    assign s_axi.rresp = r_rresp;
    assign s_axi.rlast = r_rlast;

    assign fft_rst_n = r_fft_rst_n;
    assign fft_start = r_fft_start;
    assign fft_valid = r_fft_valid;
    assign fft_in_re = r_fft_in_re;
    assign fft_in_im = r_fft_in_im;

    // ------------------------------------------------------------------
    // Write path: address capture, burst error and core input stream
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_bid        <= '0;
            r_bresp      <= c_okay;
            r_aw_ctl     <= 1'b0;
            r_aw_is_ctrl <= 1'b0;
            r_fft_rst_n  <= 1'b1;
            r_fft_start  <= 1'b0;
            r_fft_valid  <= 1'b0;
            r_fft_in_re  <= '0;
            r_fft_in_im  <= '0;
        end else begin
            if (r_w_state == c_w_addr) begin
                r_bid        <= s_axi.awid;
                r_aw_ctl     <= s_axi.awaddr[12];
                r_aw_is_ctrl <= (s_axi.awaddr[11:2] == 10'd0);
                r_bresp      <= c_okay;
            end else if (w_drop) begin
                r_bresp <= c_slverr;
            end
            r_fft_rst_n <= !w_abort;
            r_fft_valid <= w_accept;
            r_fft_start <= w_accept && (r_in_cnt == '0);
            if (w_accept) begin
                r_fft_in_re <= IN_BW'($signed(s_axi.wdata[31:16]));
                r_fft_in_im <= IN_BW'($signed(s_axi.wdata[15:0]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame counters; abort and frame completion both rewind the frame
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_rd_cnt  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_abort || w_frame_done) begin
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
                r_rd_cnt  <= '0;
            end else begin
                if (w_accept) r_in_cnt  <= r_in_cnt + 1'b1;
                if (w_res)    r_out_cnt <= r_out_cnt + 1'b1;
                if (w_rd_ok)  r_rd_cnt  <= r_rd_cnt + 1'b1;
            end
            if (w_abort) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Only the top 16 bits of each result component are ever read back.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_res) begin
            r_obuf[r_out_cnt[c_idx_w-1:0]] <= {fft_out_re[OUT_BW-1 -: 16],
                                               fft_out_im[OUT_BW-1 -: 16]};
        end
    end

    // ------------------------------------------------------------------
    // Read path: each beat is fetched into RDATA one cycle before RVALID
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rid          <= '0;
            r_arlen        <= '0;
            r_rbeat        <= '0;
            r_ar_ctl       <= 1'b0;
            r_ar_is_status <= 1'b0;
            r_rdata        <= '0;
            r_rresp        <= c_okay;
            r_rlast        <= 1'b0;
        end else begin
            case (r_r_state)
                c_r_addr: begin
                    r_rid          <= s_axi.arid;
                    r_arlen        <= s_axi.arlen;
                    r_rbeat        <= '0;
                    r_ar_ctl       <= s_axi.araddr[12];
                    r_ar_is_status <= (s_axi.araddr[11:2] == 10'd1);
                end
                c_r_fetch: begin
                    r_rlast <= (r_rbeat == r_arlen);
                    if (r_ar_ctl) begin
                        r_rdata <= r_ar_is_status ? w_status : 32'd0;
                        r_rresp <= c_okay;
                    end else if (w_rd_ok) begin
                        r_rdata <= r_obuf[r_rd_cnt[c_idx_w-1:0]];
                        r_rresp <= c_okay;
                    end else begin
                        r_rdata <= 32'd0;
                        r_rresp <= c_slverr;
                    end
                end
                c_r_data: begin
                    if (s_axi.rready) r_rbeat <= r_rbeat + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_fft_frame_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_fft_frame_slave
//  Purpose  : Directed self-checking bench for axi_fft_frame_slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_fft_frame_slave;
    localparam int c_tmo = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_fft_frame_slave_if #(.WIDTH_SID(15), .WIDTH_AD(14), .WIDTH_DA(32), .WIDTH_DS(4)) ifc ();

    logic        fft_rst_n, fft_start, fft_valid, fft_out_valid;
    logic [15:0] fft_in_re, fft_in_im;
    logic [22:0] fft_out_re, fft_out_im;

    axi_fft_frame_slave #(
        .WIDTH_SID(15), .WIDTH_AD(14), .WIDTH_DA(32), .WIDTH_DS(4),
        .N_PT(128), .IN_BW(16), .OUT_BW(23)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (ifc),
        .fft_rst_n     (fft_rst_n),
        .fft_start     (fft_start),
        .fft_valid     (fft_valid),
        .fft_in_re     (fft_in_re),
        .fft_in_im     (fft_in_im),
        .fft_out_valid (fft_out_valid),
        .fft_out_re    (fft_out_re),
        .fft_out_im    (fft_out_im)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Core-side monitor
    logic [15:0] mon_re [1024];
    logic [15:0] mon_im [1024];
    int mon_n = 0, start_cnt = 0, start_pos = -1, rstlow_cnt = 0;
    always @(negedge clk) begin
        if (fft_valid === 1'b1) begin
            mon_re[mon_n % 1024] = fft_in_re;
            mon_im[mon_n % 1024] = fft_in_im;
            if (fft_start === 1'b1) begin
                start_cnt = start_cnt + 1;
                start_pos = mon_n;
            end
            mon_n = mon_n + 1;
        end
        if (fft_rst_n === 1'b0) rstlow_cnt = rstlow_cnt + 1;
    end

    logic [31:0] beat_data [256];
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [14:0] rd_id   [256];

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic timeout_fail(input string what);
        n_tests++; n_fail++;
        $display("FAIL %s: handshake timeout", what);
    endtask

    task automatic aw_req(input logic [14:0] id, input logic [13:0] addr, input int len);
        int t = 0;
        ifc.awid = id; ifc.awaddr = addr; ifc.awlen = 8'(len); ifc.awvalid = 1'b1;
        while (ifc.awready !== 1'b1 && t < c_tmo) begin tick(1); t++; end
        if (t >= c_tmo) timeout_fail("aw");
        tick(1);
        ifc.awvalid = 1'b0;
    endtask

    task automatic w_beats(input int n, input int total);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            ifc.wdata = beat_data[i]; ifc.wlast = (i == total - 1); ifc.wvalid = 1'b1;
            while (ifc.wready !== 1'b1 && t < c_tmo) begin tick(1); t++; end
            if (t >= c_tmo) begin timeout_fail("w"); break; end
            tick(1);
        end
        ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
    endtask

    task automatic b_take(output logic [1:0] resp, output logic [14:0] id);
        int t = 0;
        ifc.bready = 1'b1;
        while (ifc.bvalid !== 1'b1 && t < c_tmo) begin tick(1); t++; end
        if (t >= c_tmo) timeout_fail("b");
        resp = ifc.bresp; id = ifc.bid;
        tick(1);
        ifc.bready = 1'b0;
    endtask

    task automatic wr_burst(input logic [14:0] id, input logic [13:0] addr, input int n,
                            output logic [1:0] resp, output logic [14:0] bid);
        aw_req(id, addr, n - 1);
        w_beats(n, n);
        b_take(resp, bid);
    endtask

    task automatic ar_req(input logic [14:0] id, input logic [13:0] addr, input int len);
        int t = 0;
        ifc.arid = id; ifc.araddr = addr; ifc.arlen = 8'(len); ifc.arvalid = 1'b1;
        while (ifc.arready !== 1'b1 && t < c_tmo) begin tick(1); t++; end
        if (t >= c_tmo) timeout_fail("ar");
        tick(1);
        ifc.arvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [14:0] id, input logic [13:0] addr, input int len);
        ar_req(id, addr, len);
        ifc.rready = 1'b1;
        for (int b = 0; b <= len; b++) begin
            int t = 0;
            while (ifc.rvalid !== 1'b1 && t < c_tmo) begin tick(1); t++; end
            if (t >= c_tmo) begin timeout_fail("r"); break; end
            rd_data[b] = ifc.rdata; rd_resp[b] = ifc.rresp;
            rd_last[b] = ifc.rlast; rd_id[b] = ifc.rid;
            tick(1);
        end
        ifc.rready = 1'b0;
    endtask

    task automatic read_status(output logic [31:0] v);
        axi_read(15'h0, 14'h1004, 0);
        v = rd_data[0];
    endtask

    task automatic abort_frame();
        logic [1:0] r; logic [14:0] id;
        beat_data[0] = 32'h1;
        wr_burst(15'h7, 14'h1000, 1, r, id);
    endtask

    task automatic feed_results(input int n);
        for (int i = 0; i < n; i++) begin
            fft_out_valid = 1'b1;
            fft_out_re = 23'(i << 7);
            fft_out_im = 23'(-(i << 7));
            tick(1);
        end
        fft_out_valid = 1'b0;
        tick(3);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] st;
        tick(4);
        n_tests++;
        if ({ifc.awready, ifc.wready, ifc.bvalid, ifc.arready, ifc.rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b expected 00000",
                     {ifc.awready, ifc.wready, ifc.bvalid, ifc.arready, ifc.rvalid});
        end
        n_tests++;
        if ({fft_rst_n, fft_start, fft_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_core: got %b expected 100", {fft_rst_n, fft_start, fft_valid});
        end
        n_tests++;
        if ({ifc.bresp, ifc.rresp, ifc.rdata} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_payload: got bresp=%0d rresp=%0d rdata=%h expected 0",
                     ifc.bresp, ifc.rresp, ifc.rdata);
        end
        rst_n = 1'b1;
        tick(2);
        read_status(st);
        n_tests++;
        if (st !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 00000000", st); end
    endtask

    task automatic test_load();
        logic [1:0] r; logic [14:0] id; logic [31:0] st;
        int v0 = mon_n, s0 = start_cnt, bad = -1;
        for (int i = 0; i < 128; i++) beat_data[i] = {16'(i), 16'(-i)};
        wr_burst(15'h1234, 14'h0000, 128, r, id);
        tick(2);
        n_tests++;
        if (mon_n - v0 != 128) begin n_fail++; $display("FAIL load_valid_count: got %0d expected 128", mon_n - v0); end
        n_tests++;
        if (start_cnt - s0 != 1 || start_pos != v0) begin
            n_fail++;
            $display("FAIL load_start: got count=%0d pos=%0d expected 1 at %0d", start_cnt - s0, start_pos, v0);
        end
        for (int i = 0; i < 128; i++)
            if (bad < 0 && {mon_re[(v0 + i) % 1024], mon_im[(v0 + i) % 1024]} !== {16'(i), 16'(-i)}) bad = i;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL load_samples: sample %0d got %h%h expected %h", bad,
                     mon_re[(v0 + bad) % 1024], mon_im[(v0 + bad) % 1024], {16'(bad), 16'(-bad)});
        end
        n_tests++;
        if (r !== 2'b00 || id !== 15'h1234) begin n_fail++; $display("FAIL load_bresp: got %0d id %h expected 0 id 1234", r, id); end
        read_status(st);
        n_tests++;
        if (st !== 32'h0000_0002) begin n_fail++; $display("FAIL load_status: got %h expected 00000002", st); end
    endtask

    task automatic test_results();
        logic [31:0] st;
        int bad = -1, bad_last = -1, bad_resp = -1;
        feed_results(128);
        read_status(st);
        n_tests++;
        if (st !== 32'h0080_0003) begin n_fail++; $display("FAIL ready_status: got %h expected 00800003", st); end
        axi_read(15'h0055, 14'h0000, 127);
        for (int i = 0; i < 128; i++) begin
            if (bad < 0 && rd_data[i] !== {16'(i), 16'(-i)}) bad = i;
            if (bad_last < 0 && rd_last[i] !== (i == 127)) bad_last = i;
            if (bad_resp < 0 && (rd_resp[i] !== 2'b00 || rd_id[i] !== 15'h0055)) bad_resp = i;
        end
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL read_data: beat %0d got %h expected %h", bad, rd_data[bad], {16'(bad), 16'(-bad)}); end
        n_tests++;
        if (bad_last >= 0) begin n_fail++; $display("FAIL read_rlast: beat %0d got %b expected %b", bad_last, rd_last[bad_last], bad_last == 127); end
        n_tests++;
        if (bad_resp >= 0) begin n_fail++; $display("FAIL read_resp: beat %0d got resp %0d id %h expected 0 id 0055", bad_resp, rd_resp[bad_resp], rd_id[bad_resp]); end
        read_status(st);
        n_tests++;
        if (st !== 32'h0) begin n_fail++; $display("FAIL frame_done_status: got %h expected 00000000", st); end
    endtask

    task automatic test_overflow();
        logic [1:0] r; logic [14:0] id; logic [31:0] st;
        int v0 = mon_n;
        for (int i = 0; i < 132; i++) beat_data[i] = {16'(i + 500), 16'(i)};
        wr_burst(15'h0042, 14'h0000, 132, r, id);
        tick(2);
        n_tests++;
        if (mon_n - v0 != 128) begin n_fail++; $display("FAIL ovf_forwarded: got %0d expected 128", mon_n - v0); end
        n_tests++;
        if (mon_re[(v0 + 127) % 1024] !== 16'd627) begin
            n_fail++; $display("FAIL ovf_last_sample: got %h expected %h", mon_re[(v0 + 127) % 1024], 16'd627);
        end
        n_tests++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL ovf_bresp: got %0d expected 2", r); end
        read_status(st);
        n_tests++;
        if (st !== 32'h0000_0006) begin n_fail++; $display("FAIL ovf_status: got %h expected 00000006", st); end
        abort_frame();
        read_status(st);
        n_tests++;
        if (st !== 32'h0) begin n_fail++; $display("FAIL ovf_clear: got %h expected 00000000", st); end
    endtask

    task automatic test_read_errors();
        logic [1:0] r; logic [14:0] id; logic [31:0] st;
        int bad = -1;
        axi_read(15'h0011, 14'h0000, 3);
        for (int i = 0; i < 4; i++)
            if (bad < 0 && (rd_data[i] !== 32'd0 || rd_resp[i] !== 2'b10)) bad = i;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL idle_read: beat %0d got %h resp %0d expected 0 resp 2", bad, rd_data[bad], rd_resp[bad]); end
        for (int i = 0; i < 128; i++) beat_data[i] = {16'(i), 16'(-i)};
        wr_burst(15'h1, 14'h0000, 128, r, id);
        feed_results(128);
        axi_read(15'h2, 14'h0000, 125);
        read_status(st);
        n_tests++;
        if (st !== 32'h0002_0003) begin n_fail++; $display("FAIL rem_status: got %h expected 00020003", st); end
        axi_read(15'h3, 14'h0000, 3);
        n_tests++;
        if ({rd_data[0], rd_resp[0], rd_data[1], rd_resp[1]} !== {16'd126, 16'(-126), 2'b00, 16'd127, 16'(-127), 2'b00}) begin
            n_fail++;
            $display("FAIL tail_ok: got %h/%0d %h/%0d expected 007eff82/0 007fff81/0", rd_data[0], rd_resp[0], rd_data[1], rd_resp[1]);
        end
        n_tests++;
        if ({rd_data[2], rd_resp[2], rd_data[3], rd_resp[3], rd_last[3], rd_last[2]} !== {32'd0, 2'b10, 32'd0, 2'b10, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL tail_err: got %h/%0d %h/%0d last %b%b expected 0/2 0/2 last 10", rd_data[2], rd_resp[2], rd_data[3], rd_resp[3], rd_last[3], rd_last[2]);
        end
    endtask

    task automatic test_abort();
        logic [1:0] r; logic [14:0] id; logic [31:0] st;
        int rl0, v0, s0;
        for (int i = 0; i < 50; i++) beat_data[i] = {16'(i), 16'(i)};
        wr_burst(15'h9, 14'h0000, 50, r, id);
        read_status(st);
        n_tests++;
        if (st !== 32'h1) begin n_fail++; $display("FAIL midload_status: got %h expected 00000001", st); end
        beat_data[0] = 32'h0;
        wr_burst(15'h9, 14'h1000, 1, r, id);
        read_status(st);
        n_tests++;
        if (st !== 32'h1) begin n_fail++; $display("FAIL ctrl_zero: got %h expected 00000001", st); end
        rl0 = rstlow_cnt;
        abort_frame();
        tick(2);
        n_tests++;
        if (rstlow_cnt - rl0 != 1) begin n_fail++; $display("FAIL abort_rst_pulse: got %0d cycles expected 1", rstlow_cnt - rl0); end
        read_status(st);
        n_tests++;
        if (st !== 32'h0) begin n_fail++; $display("FAIL abort_status: got %h expected 00000000", st); end
        v0 = mon_n; s0 = start_cnt;
        beat_data[0] = 32'hABCD_0001;
        wr_burst(15'h9, 14'h0000, 1, r, id);
        tick(2);
        n_tests++;
        if (mon_n - v0 != 1 || start_cnt - s0 != 1 || start_pos != v0) begin
            n_fail++;
            $display("FAIL abort_restart: got valid=%0d start=%0d expected 1 1", mon_n - v0, start_cnt - s0);
        end
        abort_frame();
    endtask

    task automatic test_stall_and_reset();
        logic [1:0] r; logic [14:0] id; logic [31:0] st;
        int t, bad;
        beat_data[0] = 32'h1234_5678;
        aw_req(15'h3A5C, 14'h0000, 0);
        w_beats(1, 1);
        t = 0;
        while (ifc.bvalid !== 1'b1 && t < c_tmo) begin tick(1); t++; end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({ifc.bvalid, ifc.bid, ifc.bresp} !== {1'b1, 15'h3A5C, 2'b00}) bad++;
            tick(1);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL b_stall: got %0d unstable cycles expected 0", bad); end
        b_take(r, id);
        ar_req(15'h0777, 14'h1004, 0);
        t = 0;
        while (ifc.rvalid !== 1'b1 && t < c_tmo) begin tick(1); t++; end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({ifc.rvalid, ifc.rdata, ifc.rid, ifc.rresp, ifc.rlast} !== {1'b1, 32'h1, 15'h0777, 2'b00, 1'b1}) bad++;
            tick(1);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL r_stall: got %0d unstable cycles expected 0", bad); end
        ifc.rready = 1'b1; tick(1); ifc.rready = 1'b0;
        // Interrupt an open write burst and an open read burst with reset
        beat_data[0] = 32'h1; beat_data[1] = 32'h2;
        aw_req(15'h1, 14'h0000, 7);
        w_beats(2, 8);
        ar_req(15'h2, 14'h1004, 3);
        t = 0;
        while (ifc.rvalid !== 1'b1 && t < c_tmo) begin tick(1); t++; end
        ifc.wvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ifc.awready, ifc.wready, ifc.bvalid, ifc.arready, ifc.rvalid, fft_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 000000",
                     {ifc.awready, ifc.wready, ifc.bvalid, ifc.arready, ifc.rvalid, fft_valid});
        end
        ifc.wvalid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifc.bvalid !== 1'b0 || ifc.rvalid !== 1'b0) bad++;
            tick(1);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL post_reset_resp: got %0d response cycles expected 0", bad); end
        read_status(st);
        n_tests++;
        if (st !== 32'h0) begin n_fail++; $display("FAIL post_reset_status: got %h expected 00000000", st); end
    endtask

    initial begin
        ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = 3'd2; ifc.awburst = 2'd1; ifc.awvalid = 1'b0;
        ifc.wdata = '0; ifc.wstrb = 4'hF; ifc.wlast = 1'b0; ifc.wvalid = 1'b0; ifc.bready = 1'b0;
        ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = 3'd2; ifc.arburst = 2'd1; ifc.arvalid = 1'b0;
        ifc.rready = 1'b0;
        fft_out_valid = 1'b0; fft_out_re = '0; fft_out_im = '0;
        test_reset();
        test_load();
        test_results();
        test_overflow();
        test_read_errors();
        test_abort();
        test_stall_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
